// File: rtl/vram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vram_arbiter_pkg
// Shared types for the display-memory arbiter: address/data word types, the
// host-port FSM state encoding, the host request hold-register layout and a
// saturating increment helper for the host wait counter.
// -----------------------------------------------------------------------------
package vram_arbiter_pkg;

  localparam int DISP_ADDR_W = 16;
  localparam int DISP_DATA_W = 16;
  localparam int ARB_WAIT_W  = 8;

  typedef logic [DISP_ADDR_W-1:0] disp_addr_t;
  typedef logic [DISP_DATA_W-1:0] disp_data_t;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_PEND = 1'b1
  } vram_arb_st;

  // Host request captured at acceptance and replayed when video leaves a slot.
  typedef struct packed {
    logic       wr;
    disp_addr_t addr;
    disp_data_t wdata;
  } host_req_t;

  // Saturating +1 so a very long starvation never wraps the counter back to 0.
  function automatic logic [ARB_WAIT_W-1:0] wait_sat_inc(input logic [ARB_WAIT_W-1:0] v);
    logic [ARB_WAIT_W-1:0] r;
    if (v == {ARB_WAIT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + ARB_WAIT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares the single-port display memory between the video fetch engine and a
// host port. Video reads win every cycle they are requested and reach memory
// combinationally, so video read latency is exactly the memory latency. The
// host request is held in a register and issued in the first video-idle cycle.
//
// Ports
//   clk, reset_n          pixel clock, asynchronous active-low reset
//   vid_sel_i/vid_addr_i  video read select and word address
//   vid_data_o            video read data (straight from mem_data_i)
//   host_req_i            host request strobe, sampled only while not busy
//   host_wr_i             1 = write, 0 = read
//   host_addr_i/_wdata_i  host word address / write data
//   host_busy_o           a host request is held and not yet issued
//   host_rd_valid_o       one-cycle pulse, host_rd_data_o valid
//   host_rd_data_o        registered host read data
//   host_starved_o        sticky flag, host waited MAX_WAIT video cycles
//   mem_sel_o/mem_wr_o    memory select / write enable
//   mem_addr_o/_wdata_o   memory address / write data
//   mem_data_i            memory read data, MEM_LAT cycles after select
// -----------------------------------------------------------------------------
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vid_sel_i,
  input  disp_addr_t vid_addr_i,
  output disp_data_t vid_data_o,
  input  logic       host_req_i,
  input  logic       host_wr_i,
  input  disp_addr_t host_addr_i,
  input  disp_data_t host_wdata_i,
  output logic       host_busy_o,
  output logic       host_rd_valid_o,
  output disp_data_t host_rd_data_o,
  output logic       host_starved_o,
  output logic       mem_sel_o,
  output logic       mem_wr_o,
  output disp_addr_t mem_addr_o,
  output disp_data_t mem_wdata_o,
  input  disp_data_t mem_data_i
);

  localparam logic [ARB_WAIT_W-1:0] STARVE_AT = ARB_WAIT_W'(MAX_WAIT - 1);

  vram_arb_st            state_q, state_d;
  host_req_t             hold_q, hold_d;
  logic [ARB_WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  starved_q, starved_d;
  logic [MEM_LAT-1:0]    rd_pipe_q, rd_pipe_d;
  logic                  rd_valid_q, rd_valid_d;
  disp_data_t            rd_data_q, rd_data_d;
  logic                  issue_s;
  logic                  rd_capture_s;

  // Host FSM next state: accept in IDLE, issue or wait (and count) in PEND.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    wait_cnt_d = wait_cnt_q;
    starved_d  = starved_q;
    issue_s    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (host_req_i) begin
          hold_d.wr    = host_wr_i;
          hold_d.addr  = host_addr_i;
          hold_d.wdata = host_wdata_i;
          state_d      = ARB_PEND;
          starved_d    = 1'b0;
          wait_cnt_d   = '0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_PEND: begin
        if (!vid_sel_i) begin
          issue_s    = 1'b1;
          state_d    = ARB_IDLE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_sat_inc(wait_cnt_q);
          // The flag rises on the stall that completes MAX_WAIT waited cycles.
          if (wait_cnt_q >= STARVE_AT) begin
            starved_d = 1'b1;
          end else begin
            starved_d = starved_q;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Read-return pipeline: a host read issue travels MEM_LAT stages, then the
  // memory word is captured and the valid pulse is raised for one cycle.
  always_comb begin
    rd_pipe_d    = '0;
    rd_pipe_d[0] = issue_s & ~hold_q.wr;
    for (int i = 1; i < int'(MEM_LAT); i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end
    rd_capture_s = rd_pipe_q[MEM_LAT-1];
    rd_valid_d   = rd_capture_s;
    if (rd_capture_s) begin
      rd_data_d = mem_data_i;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // State and registered outputs; reset drops any pending or in-flight host access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      hold_q     <= '0;
      wait_cnt_q <= '0;
      starved_q  <= 1'b0;
      rd_pipe_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      wait_cnt_q <= wait_cnt_d;
      starved_q  <= starved_d;
      rd_pipe_q  <= rd_pipe_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Memory port mux: video first, then the held host request; address and
  // write data rest on the hold register when nobody selects memory.
  always_comb begin
    mem_wdata_o = hold_q.wdata;
    if (vid_sel_i) begin
      mem_sel_o  = 1'b1;
      mem_wr_o   = 1'b0;
      mem_addr_o = vid_addr_i;
    end else if (state_q == ARB_PEND) begin
      mem_sel_o  = 1'b1;
      mem_wr_o   = hold_q.wr;
      mem_addr_o = hold_q.addr;
    end else begin
      mem_sel_o  = 1'b0;
      mem_wr_o   = 1'b0;
      mem_addr_o = hold_q.addr;
    end
  end

  assign vid_data_o      = mem_data_i;
  assign host_busy_o     = (state_q == ARB_PEND);
  assign host_rd_valid_o = rd_valid_q;
  assign host_rd_data_o  = rd_data_q;
  assign host_starved_o  = starved_q;

endmodule
